uart_receiver: RTL and testbench

Serial-to-parallel UART receive path, the counterpart of the team's 8N1/8N2 transmitter. Samples the asynchronous RxD line with 16x oversampling, validates start and stop bits, and presents each received byte for exactly one clock cycle with a done strobe. Sits between the FPGA pin and the byte-level consumer (loopback test, command parser).

---
 rtl/uart_receiver.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receive path (8N1 by default).
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing with an extra
// PARITY state and an RxD_parity_err strobe.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   RxD            asynchronous serial line, idle high
//   RxD_data       last valid received byte (LSB first on the line)
//   RxD_done       one-cycle strobe: byte with valid stop bit received
//   RxD_idle       line high for at least 10 bit periods since last frame
//   RxD_frame_err  one-cycle strobe: bad stop bit (or parity), byte dropped
//   RxD_parity_err one-cycle strobe with RxD_frame_err on parity mismatch
//                  (UART_RX_PARITY_EN only)
module uart_receiver #(
  parameter int unsigned ClkFrequency = 100000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_done,
  output logic       RxD_idle,
  output logic       RxD_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       RxD_parity_err
`endif
);

  // Tick generator sizing: 8 fractional bits beyond the clk/tick ratio keep
  // the rate error far below 2%.
  localparam int unsigned TickRate  = Baud * Oversampling;
  localparam int unsigned AccWidth  = $clog2(ClkFrequency / TickRate) + 8;
  localparam logic [63:0] IncWide   = ((64'(TickRate) << AccWidth) + 64'(ClkFrequency / 2))
                                      / 64'(ClkFrequency);
  localparam logic [AccWidth-1:0] AccInc = IncWide[AccWidth-1:0];

  localparam int unsigned CntWidth  = $clog2(Oversampling);
  localparam logic [CntWidth-1:0] MidCnt = CntWidth'(Oversampling / 2 - 1);

  localparam int unsigned GapMax    = 10 * Oversampling;
  localparam int unsigned GapWidth  = $clog2(GapMax + 1);
  localparam logic [GapWidth-1:0] GapSat = GapWidth'(GapMax);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK_WAIT
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY
`endif
  } state_t;

  // Oversample tick: carry out of the phase accumulator
  logic [AccWidth-1:0] acc;
  logic [AccWidth:0]   acc_sum;
  logic                tick;

  assign acc_sum = {1'b0, acc} + {1'b0, AccInc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= acc_sum[AccWidth-1:0];
      tick <= acc_sum[AccWidth];
    end
  end

  // Synchronizer plus 2-of-3 majority over the last three ticks
  logic [1:0] sync_q;
  logic [2:0] samp;
  logic       filtered;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      samp   <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], RxD};
      if (tick) begin
        samp <= {samp[1:0], sync_q[1]};
      end
    end
  end

  assign filtered = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  // FSM and datapath registers
  state_t               state, state_n;
  logic [CntWidth-1:0]  cnt, cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [7:0]           shift, shift_n;
  logic [GapWidth-1:0]  gap, gap_n;
  logic [7:0]           data_n;
  logic                 done_n;
  logic                 ferr_n;
  logic                 idle_n;
  logic                 mid;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_bit_n;
  logic                 perr_n;
`endif

  assign mid = tick && (cnt == MidCnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      gap           <= '0;
      RxD_data      <= 8'h00;
      RxD_done      <= 1'b0;
      RxD_frame_err <= 1'b0;
      RxD_idle      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit        <= 1'b0;
      RxD_parity_err <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_idx_n;
      shift         <= shift_n;
      gap           <= gap_n;
      RxD_data      <= data_n;
      RxD_done      <= done_n;
      RxD_frame_err <= ferr_n;
      RxD_idle      <= idle_n;
`ifdef UART_RX_PARITY_EN
      par_bit        <= par_bit_n;
      RxD_parity_err <= perr_n;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    gap_n     = gap;
    data_n    = RxD_data;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
    perr_n    = 1'b0;
`endif

    if (tick) begin
      cnt_n = cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (tick) begin
          if (!filtered) begin
            state_n = S_START;
            cnt_n   = '0;
            gap_n   = '0;
          end else if (gap != GapSat) begin
            gap_n = gap + 1'b1;
          end
        end
      end

      S_START: begin
        if (mid) begin
          if (filtered) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_DATA;
            bit_idx_n = '0;
          end
        end
      end

      S_DATA: begin
        if (mid) begin
          shift_n = {filtered, shift[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          par_bit_n = filtered;
          state_n   = S_STOP;
        end
      end
`endif

      // IDLE is re-entered at mid-stop so a following start edge is not missed
      S_STOP: begin
        if (mid) begin
          if (filtered) begin
            state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if ((^shift) != par_bit) begin
              ferr_n = 1'b1;
              perr_n = 1'b1;
            end else begin
              data_n = shift;
              done_n = 1'b1;
            end
`else
            data_n = shift;
            done_n = 1'b1;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK_WAIT;
          end
        end
      end

      S_BREAK_WAIT: begin
        if (tick && filtered) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Gap counter is zero outside IDLE, so this also clears on START entry
    idle_n = (gap_n == GapSat);
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed checks of uart_receiver framing, glitch
// rejection, framing errors, idle detection and mid-frame reset.
// The DUT runs at 1 Mbaud on a 100 MHz clock (100 clocks per bit).
module tb_uart_receiver;

  localparam int unsigned ClkHz = 100000000;
  localparam int unsigned BaudR = 1000000;
  localparam int unsigned BitNs = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_idle;
  logic       rx_ferr;
`ifdef UART_RX_PARITY_EN
  logic       rx_perr;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned done_cnt = 0;
  int unsigned ferr_cnt = 0;
  int unsigned both_cnt = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  d;

  uart_receiver #(
    .ClkFrequency (ClkHz),
    .Baud         (BaudR),
    .Oversampling (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RxD           (rxd),
    .RxD_data      (rx_data),
    .RxD_done      (rx_done),
    .RxD_idle      (rx_idle),
    .RxD_frame_err (rx_ferr)
`ifdef UART_RX_PARITY_EN
    ,
    .RxD_parity_err(rx_perr)
`endif
  );

  always #5 clk = ~clk;

  // Count strobe cycles and capture bytes away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done) begin
        done_cnt++;
        rx_q.push_back(rx_data);
      end
      if (rx_ferr) ferr_cnt++;
      if (rx_done && rx_ferr) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rxd = 1'b0;
    #(BitNs);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(BitNs);
    end
`ifdef UART_RX_PARITY_EN
    rxd = ^b;
    #(BitNs);
`endif
    rxd = stop_val;
    #(BitNs);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    d = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check(tag, 32'(d), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_done", 32'(rx_done), 32'h0);
    check("rst_idle", 32'(rx_idle), 32'h0);
    check("rst_ferr", 32'(rx_ferr), 32'h0);

    // Idle needs 10 bit periods of high line
    #(9 * BitNs);
    check("idle_9bit", 32'(rx_idle), 32'h0);
    #(2 * BitNs);
    check("idle_11bit", 32'(rx_idle), 32'h1);

    send_byte(8'hA5, 1'b1);
    check("a5_done_cnt", done_cnt, 1);
    pop_check("a5_data", 8'hA5);
    check("a5_ferr_cnt", ferr_cnt, 0);
    check("idle_after_frame", 32'(rx_idle), 32'h0);

    // Back to back, one stop bit each
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    check("b2b_done_cnt", done_cnt, 4);
    pop_check("b2b_data0", 8'h00);
    pop_check("b2b_data1", 8'hFF);
    pop_check("b2b_data2", 8'h55);
    check("b2b_ferr_cnt", ferr_cnt, 0);

    // Short low glitch well under half a bit
    rxd = 1'b0;
    #(300);
    rxd = 1'b1;
    #(12 * BitNs);
    check("glitch_done_cnt", done_cnt, 4);
    check("glitch_ferr_cnt", ferr_cnt, 0);
    check("glitch_idle", 32'(rx_idle), 32'h1);

    // Stop bit low, line held low (break), then released
    send_byte(8'h3C, 1'b0);
    #(20 * BitNs);
    rxd = 1'b1;
    #(2 * BitNs);
    check("brk_ferr_cnt", ferr_cnt, 1);
    check("brk_done_cnt", done_cnt, 4);
    check("brk_data_hold", 32'(rx_data), 32'h55);
    send_byte(8'h81, 1'b1);
    #(BitNs);
    check("post_brk_done_cnt", done_cnt, 5);
    pop_check("post_brk_data", 8'h81);
    check("post_brk_ferr_cnt", ferr_cnt, 1);

    // Reset in the middle of bit 4 of 8'hC3
    rxd = 1'b0;
    #(BitNs);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'hC3 >> i) & 8'h01;
      #(BitNs);
    end
    rxd = 1'b0;
    #(BitNs / 2);
    @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_data_rst", 32'(rx_data), 32'h00);
    #(12 * BitNs);
    check("abort_done_cnt", done_cnt, 5);
    check("abort_ferr_cnt", ferr_cnt, 1);
    send_byte(8'h7E, 1'b1);
    #(BitNs);
    check("7e_done_cnt", done_cnt, 6);
    pop_check("7e_data", 8'h7E);
    check("7e_data_port", 32'(rx_data), 32'h7E);

    check("done_ferr_overlap", both_cnt, 0);
    check("no_extra_bytes", rx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
